bird_physics: RTL and testbench
===============================

Name: bird_physics

Overview:
- Consumes the one-cycle click pulse produced by the button debouncer and turns it into the bird's vertical motion for the game.
- Integrates gravity and flap impulses once per frame tick (ce) and clamps the bird to the screen.
- Runs the game-life state machine IDLE -> FLYING -> DEAD.
- Feeds bird_y to the renderer and pipe-collision logic; takes the collision verdict back.

Parameters:
Y_WIDTH, 10, width of the unsigned bird_y pixel coordinate
VEL_WIDTH, 8, width of the signed velocity in px/frame (two's complement)
SCREEN_HEIGHT, 480, playfield height in pixels
BIRD_HEIGHT, 16, bird sprite height; floor position is SCREEN_HEIGHT-BIRD_HEIGHT
START_Y, 232, bird_y in IDLE
GRAVITY, 1, velocity increment per frame tick (positive = downward)
FLAP_SPEED, 8, magnitude of the upward velocity set by a flap
MAX_FALL_SPEED, 10, downward velocity cap, used only with the optional feature

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ce  input  1  frame tick, one clk cycle per frame
flap  input  1  one-cycle click pulse from the debouncer (btn_click), arrives at any clk cycle
collision  input  1  pipe collision flag, sampled only on ce
bird_y  output  Y_WIDTH  bird top coordinate, 0 = top of screen
bird_vel  output  VEL_WIDTH  signed current velocity
state  output  2  bird_state_t encoding
alive  output  1  high when state is FLYING
game_over  output  1  one-cycle pulse on entry to DEAD

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high, and overrides ce, flap and collision.
- Reset values: state=IDLE, bird_y=START_Y, bird_vel=0, alive=0, game_over=0, flap_pending=0.
- Flap latch:
  - flap sets flap_pending.
  - A ce cycle consumes flap_pending OR flap (a flap coincident with ce counts for that tick), then clears the latch.
  - Several flaps between ticks count as one.
- All state, position and velocity updates occur only on ce cycles. Outputs are registered, so new values are visible the cycle after ce.
- IDLE on ce:
  - With a flap: go to FLYING, bird_vel=-FLAP_SPEED, bird_y unchanged.
  - Without a flap: hold. collision is ignored.
- FLYING on ce: compute v' first, then y':
  - v' = -FLAP_SPEED if a flap is consumed, else bird_vel+GRAVITY saturated at the +max of VEL_WIDTH.
  - y' = bird_y + v', computed in Y_WIDTH+2 signed bits.
  - If collision: go to DEAD, pulse game_over; position and velocity freeze at their current values (no update this tick).
  - Else if y' >= SCREEN_HEIGHT-BIRD_HEIGHT: bird_y = SCREEN_HEIGHT-BIRD_HEIGHT, bird_vel=0, go to DEAD, pulse game_over.
  - Else if y' < 0: bird_y=0, bird_vel=0, stay in FLYING (the ceiling is not fatal).
  - Else: bird_y=y', bird_vel=v'.
- DEAD on ce:
  - With a flap: go to IDLE, reload START_Y and velocity 0, clear the latch.
  - Without a flap: hold.
- game_over is high for exactly one clk cycle and is never re-asserted while in DEAD.
- A flap arriving in the same cycle as rst is discarded.

Optional Feature:
BIRD_PHYSICS_TERMINAL_VELOCITY_EN
- Defined: in FLYING, the no-flap v' = min(bird_vel+GRAVITY, MAX_FALL_SPEED).
- Undefined: no cap; velocity saturates only at the VEL_WIDTH maximum (127 at default).
- Flap and ceiling/floor rules are identical in both builds.

Decomposition:
- Package bird_pkg holds:
  - typedef enum logic [1:0] bird_state_t {BIRD_IDLE=0, BIRD_FLYING=1, BIRD_DEAD=2};
  - SCREEN_HEIGHT and BIRD_HEIGHT constants, which the renderer and collision logic share.
- No sub-module; the flap latch and saturating adder stay inline. The top level instantiates btn_debouncer and connects btn_click to flap.

Test Plan:
1. Reset, then a flap pulse 3 cycles before a ce -> after that ce: state=FLYING, bird_y=232, bird_vel=-8. Eight further ce with no flap -> bird_vel=0, bird_y=204.
2. Flap coincident with ce in FLYING at bird_vel=3 -> bird_vel=-8, bird_y decreases by 8. Three flaps between two ticks -> exactly one impulse.
3. Flap every tick from bird_y=10 -> y' goes negative -> bird_y=0, bird_vel=0, state stays FLYING, game_over=0.
4. Free fall until y' >= 464 -> bird_y=464, state=DEAD, game_over high exactly 1 cycle. Later ticks without flap hold all outputs; a flap -> IDLE, bird_y=232.
5. collision=1 on a ce in FLYING -> DEAD with position frozen. collision=1 in IDLE -> ignored.
6. rst asserted mid-flight together with ce and flap -> next cycle shows all reset values. With BIRD_PHYSICS_TERMINAL_VELOCITY_EN, a long fall caps bird_vel at 10; without it, bird_vel reaches 11.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared game types and playfield geometry for the bird, renderer and collision logic.
package bird_pkg;

   typedef enum logic [1:0] {
      BIRD_IDLE   = 2'd0,
      BIRD_FLYING = 2'd1,
      BIRD_DEAD   = 2'd2
   } bird_state_t;

   localparam int SCREEN_HEIGHT = 480;
   localparam int BIRD_HEIGHT   = 16;

endpackage

// File: rtl/bird_physics.sv
// Bird vertical physics and game-life FSM, advanced once per frame tick (ce).
// Optional macro BIRD_PHYSICS_TERMINAL_VELOCITY_EN caps falling speed at MAX_FALL_SPEED.
module bird_physics
   import bird_pkg::*;
#(
   parameter int Y_WIDTH        = 10,
   parameter int VEL_WIDTH      = 8,
   parameter int SCREEN_HEIGHT  = bird_pkg::SCREEN_HEIGHT,
   parameter int BIRD_HEIGHT    = bird_pkg::BIRD_HEIGHT,
   parameter int START_Y        = 232,
   parameter int GRAVITY        = 1,
   parameter int FLAP_SPEED     = 8,
   parameter int MAX_FALL_SPEED = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ce,
   input  logic                        flap,
   input  logic                        collision,
   output logic [Y_WIDTH-1:0]          bird_y,
   output logic signed [VEL_WIDTH-1:0] bird_vel,
   output logic [1:0]                  state,
   output logic                        alive,
   output logic                        game_over
);

   localparam logic signed [VEL_WIDTH:0]   VEL_MAX  = (VEL_WIDTH+1)'(2**(VEL_WIDTH-1) - 1);
   localparam logic signed [VEL_WIDTH:0]   FALL_MAX = (VEL_WIDTH+1)'(MAX_FALL_SPEED);
   localparam logic signed [VEL_WIDTH:0]   GRAV     = (VEL_WIDTH+1)'(GRAVITY);
   localparam logic signed [VEL_WIDTH-1:0] FLAP_VEL = VEL_WIDTH'(-FLAP_SPEED);
   localparam logic signed [Y_WIDTH+1:0]   FLOOR_Y  = (Y_WIDTH+2)'(SCREEN_HEIGHT - BIRD_HEIGHT);
   localparam logic [Y_WIDTH-1:0]          START_POS = Y_WIDTH'(START_Y);

   bird_state_t                 state_q;
   logic                        flap_pending;
   logic                        flap_now;
   logic signed [VEL_WIDTH-1:0] vel_next;
   logic signed [Y_WIDTH+1:0]   y_next;

   // Gravity step with one guard bit so the add itself can never wrap.
   function automatic logic signed [VEL_WIDTH-1:0] fall_step(input logic signed [VEL_WIDTH-1:0] v);
      logic signed [VEL_WIDTH:0] sum;
      sum = (VEL_WIDTH+1)'(v) + GRAV;
`ifdef BIRD_PHYSICS_TERMINAL_VELOCITY_EN
      if (sum > FALL_MAX) sum = FALL_MAX;
`endif
      if (sum > VEL_MAX) sum = VEL_MAX;
      return sum[VEL_WIDTH-1:0];
   endfunction

   always_comb begin
      flap_now = flap_pending | flap;
      vel_next = flap_now ? FLAP_VEL : fall_step(bird_vel);
      y_next   = $signed({2'b00, bird_y}) + (Y_WIDTH+2)'(vel_next);
   end

   assign state = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= BIRD_IDLE;
         bird_y       <= START_POS;
         bird_vel     <= '0;
         alive        <= 1'b0;
         game_over    <= 1'b0;
         flap_pending <= 1'b0;
      end else begin
         game_over <= 1'b0;
         if (ce) begin
            flap_pending <= 1'b0;
            case (state_q)
               BIRD_IDLE: begin
                  if (flap_now) begin
                     state_q  <= BIRD_FLYING;
                     bird_vel <= FLAP_VEL;
                     alive    <= 1'b1;
                  end
               end
               BIRD_FLYING: begin
                  if (collision) begin
                     state_q   <= BIRD_DEAD;
                     alive     <= 1'b0;
                     game_over <= 1'b1;
                  end else if (y_next >= FLOOR_Y) begin
                     bird_y    <= FLOOR_Y[Y_WIDTH-1:0];
                     bird_vel  <= '0;
                     state_q   <= BIRD_DEAD;
                     alive     <= 1'b0;
                     game_over <= 1'b1;
                  end else if (y_next < 0) begin
                     bird_y   <= '0;
                     bird_vel <= '0;
                  end else begin
                     bird_y   <= y_next[Y_WIDTH-1:0];
                     bird_vel <= vel_next;
                  end
               end
               BIRD_DEAD: begin
                  if (flap_now) begin
                     state_q  <= BIRD_IDLE;
                     bird_y   <= START_POS;
                     bird_vel <= '0;
                  end
               end
               default: begin
                  state_q <= BIRD_IDLE;
                  alive   <= 1'b0;
               end
            endcase
         end else if (flap) begin
            flap_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: flap latch, integration, ceiling, floor, collision, reset.
module tb_bird_physics;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              ce = 1'b0;
   logic              flap = 1'b0;
   logic              collision = 1'b0;
   logic [9:0]        bird_y;
   logic signed [7:0] bird_vel;
   logic [1:0]        state;
   logic              alive;
   logic              game_over;

   int total = 0;
   int bad = 0;

   bird_physics dut (
      .clk(clk), .rst(rst), .ce(ce), .flap(flap), .collision(collision),
      .bird_y(bird_y), .bird_vel(bird_vel), .state(state), .alive(alive), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // One clk cycle with the given inputs; outputs are sampled 1 ns after the edge.
   task automatic cycle(input logic c, input logic f, input logic col);
      @(negedge clk);
      ce = c; flap = f; collision = col;
      @(posedge clk);
      #1;
      ce = 1'b0; flap = 1'b0; collision = 1'b0;
   endtask

   task automatic expect_all(input string name, input logic [1:0] es, input logic [9:0] ey,
                             input logic signed [7:0] ev, input logic ea, input logic eg);
      total++;
      if (state !== es || bird_y !== ey || bird_vel !== ev || alive !== ea || game_over !== eg) begin
         bad++;
         $display("FAIL %s: got st=%0d y=%0d v=%0d alive=%b go=%b, want st=%0d y=%0d v=%0d alive=%b go=%b",
                  name, state, bird_y, bird_vel, alive, game_over, es, ey, ev, ea, eg);
      end
   endtask

   task automatic test_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      #1;
      expect_all("reset", 2'd0, 10'd232, 8'sd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      expect_all("idle_hold", 2'd0, 10'd232, 8'sd0, 1'b0, 1'b0);
   endtask

   task automatic test_first_flap();
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      expect_all("latched_no_tick", 2'd0, 10'd232, 8'sd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      expect_all("launch", 2'd1, 10'd232, -8'sd8, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);
      expect_all("rise_to_apex", 2'd1, 10'd204, 8'sd0, 1'b1, 1'b0);
   endtask

   task automatic test_flap_latch();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
      expect_all("fall_to_v3", 2'd1, 10'd210, 8'sd3, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      expect_all("flap_with_ce", 2'd1, 10'd202, -8'sd8, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      expect_all("three_flaps_one_impulse", 2'd1, 10'd194, -8'sd8, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      expect_all("latch_cleared", 2'd1, 10'd187, -8'sd7, 1'b1, 1'b0);
   endtask

   task automatic test_ceiling();
      for (int i = 0; i < 23; i++) cycle(1'b1, 1'b1, 1'b0);
      expect_all("near_ceiling", 2'd1, 10'd3, -8'sd8, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      expect_all("ceiling_clamp", 2'd1, 10'd0, 8'sd0, 1'b1, 1'b0);
   endtask

   task automatic test_floor();
      for (int i = 0; i < 29; i++) cycle(1'b1, 1'b0, 1'b0);
      expect_all("free_fall", 2'd1, 10'd435, 8'sd29, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      expect_all("floor_hit", 2'd2, 10'd464, 8'sd0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      expect_all("game_over_one_cycle", 2'd2, 10'd464, 8'sd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1);
      expect_all("dead_hold", 2'd2, 10'd464, 8'sd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      expect_all("dead_to_idle", 2'd0, 10'd232, 8'sd0, 1'b0, 1'b0);
   endtask

   task automatic test_collision();
      cycle(1'b1, 1'b0, 1'b1);
      expect_all("idle_ignores_collision", 2'd0, 10'd232, 8'sd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      expect_all("pre_collision", 2'd1, 10'd225, -8'sd7, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      expect_all("collision_without_ce", 2'd1, 10'd225, -8'sd7, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1);
      expect_all("collision_freeze", 2'd2, 10'd225, -8'sd7, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0);
      expect_all("collision_restart", 2'd0, 10'd232, 8'sd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midflight();
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1; ce = 1'b1; flap = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; ce = 1'b0; flap = 1'b0;
      expect_all("reset_midflight", 2'd0, 10'd232, 8'sd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      expect_all("reset_drops_flap", 2'd0, 10'd232, 8'sd0, 1'b0, 1'b0);
   endtask

   task automatic test_long_fall();
      cycle(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 19; i++) cycle(1'b1, 1'b0, 1'b0);
`ifdef BIRD_PHYSICS_TERMINAL_VELOCITY_EN
      expect_all("long_fall_capped", 2'd1, 10'd269, 8'sd10, 1'b1, 1'b0);
`else
      expect_all("long_fall_uncapped", 2'd1, 10'd270, 8'sd11, 1'b1, 1'b0);
`endif
   endtask

   initial begin
      test_reset();
      test_first_flap();
      test_flap_latch();
      test_ceiling();
      test_floor();
      test_collision();
      test_reset_midflight();
      test_long_fall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
